// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: FSM states, digit
// operations and the iteration-count helper.
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_ZERO = 3'd0,
        OP_PA   = 3'd1,
        OP_P2A  = 3'd2,
        OP_NA   = 3'd3,
        OP_N2A  = 3'd4
    } op_t;

    // One radix-4 digit per two bits of the (WIDTH+2)-bit extended multiplier.
    function automatic int unsigned booth_iters(input int unsigned width);
        return (width + 2) / 2;
    endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth recoder: maps the window {b[2i+1], b[2i], b[2i-1]} to a
// multiplicand operation in {0, +A, +2A, -A, -2A}.
module booth_r4_recoder
    import booth_pkg::*;
(
    input  logic [2:0] i_window,
    output logic [2:0] o_op
);

    op_t w_op;

    always_comb begin
        w_op = OP_ZERO;
        unique case (i_window)
            3'b001, 3'b010: w_op = OP_PA;
            3'b011:         w_op = OP_P2A;
            3'b100:         w_op = OP_N2A;
            3'b101, 3'b110: w_op = OP_NA;
            default:        w_op = OP_ZERO;
        endcase
    end

    assign o_op = w_op;

endmodule

// File: rtl/booth_multiplier_r4.sv
// Sequential radix-4 Booth multiplier with valid/ready on both sides and a
// per-operation signed/unsigned mode; retires one Booth digit per CALC cycle.
module booth_multiplier_r4
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned N  = booth_iters(WIDTH);
    localparam int unsigned CW = $clog2(N);
    localparam int unsigned EW = WIDTH + 2;
    localparam int unsigned AW = 2 * WIDTH + 4;
    localparam int unsigned PW = 2 * WIDTH;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [EW-1:0]   r_a_ext;
    logic [EW:0]     r_mult_sh;
    logic [AW-1:0]   r_acc;
    logic [PW-1:0]   r_product;

    logic [EW-1:0]   w_a_in;
    logic [EW-1:0]   w_b_in;
    logic [AW-1:0]   w_a_se;
    logic [AW-1:0]   w_pp;
    logic [AW-1:0]   w_acc_next;
    logic [2:0]      w_op_bits;
    op_t             w_op;
    logic            w_accept;
    logic            w_last;

    assign w_a_in   = is_signed ? {{2{multiplicand[WIDTH-1]}}, multiplicand} : {2'b00, multiplicand};
    assign w_b_in   = is_signed ? {{2{multiplier[WIDTH-1]}}, multiplier} : {2'b00, multiplier};
    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_cnt == CW'(N - 1));
    assign w_a_se   = {{(AW - EW){r_a_ext[EW-1]}}, r_a_ext};

    booth_r4_recoder u_recoder (
        .i_window (r_mult_sh[2:0]),
        .o_op     (w_op_bits)
    );

    assign w_op = op_t'(w_op_bits);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: if (in_valid) w_state_next = ST_CALC;
            ST_CALC: if (w_last) w_state_next = ST_DONE;
            ST_DONE: if (out_ready) w_state_next = in_valid ? ST_CALC : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
        out_valid = (r_state == ST_DONE);
        busy      = (r_state == ST_CALC);
    end

    // Partial product is placed at weight 4^cnt; the window shifts down instead.
    always_comb begin
        w_pp = '0;
        unique case (w_op)
            OP_PA:   w_pp = w_a_se;
            OP_P2A:  w_pp = w_a_se << 1;
            OP_NA:   w_pp = -w_a_se;
            OP_N2A:  w_pp = -(w_a_se << 1);
            default: w_pp = '0;
        endcase
        w_acc_next = r_acc + (w_pp << {r_cnt, 1'b0});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_a_ext   <= '0;
            r_mult_sh <= '0;
            r_acc     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_cnt     <= '0;
            r_a_ext   <= w_a_in;
            r_mult_sh <= {w_b_in, 1'b0};
            r_acc     <= '0;
        end else if (r_state == ST_CALC) begin
            r_cnt     <= r_cnt + CW'(1);
            r_mult_sh <= r_mult_sh >> 2;
            r_acc     <= w_acc_next;
            if (w_last) begin
                r_product <= w_acc_next[PW-1:0];
            end
        end
    end

    assign product = r_product;

endmodule

// File: tb/tb_booth_multiplier_r4.sv
// Scoreboard bench for booth_multiplier_r4: drivers push expected products,
// per-instance monitors pop and compare on each output handshake.
module tb_booth_multiplier_r4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // WIDTH=8 instance
    logic        rst8, iv8, ir8, s8, ov8, or8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    // WIDTH=4 instance
    logic        rst4, iv4, ir4, s4, ov4, or4, busy4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;

    booth_multiplier_r4 #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(rst8), .in_valid(iv8), .in_ready(ir8),
        .multiplicand(a8), .multiplier(b8), .is_signed(s8),
        .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8)
    );

    booth_multiplier_r4 #(.WIDTH(4)) dut4 (
        .clk(clk), .reset_n(rst4), .in_valid(iv4), .in_ready(ir4),
        .multiplicand(a4), .multiplier(b4), .is_signed(s4),
        .out_valid(ov4), .out_ready(or4), .product(p4), .busy(busy4)
    );

    logic [15:0] q8[$];
    int          aq8[$];
    logic [7:0]  q4[$];
    int          aq4[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitors: latency measured from accepting edge to out_valid rise.
    logic pv8 = 1'b0, pv4 = 1'b0;
    always @(negedge clk) begin
        if (!rst8) begin
            pv8 = 1'b0;
        end else begin
            if (ov8 && !pv8) begin
                if (aq8.size() == 0) flag("unexpected_valid8");
                else chk("latency8", cyc - aq8.pop_front(), 5);
            end
            if (ov8 && or8) begin
                if (q8.size() == 0) flag("unexpected_result8");
                else chk("product8", {16'h0, p8}, {16'h0, q8.pop_front()});
            end
            pv8 = ov8;
        end
    end

    always @(negedge clk) begin
        if (!rst4) begin
            pv4 = 1'b0;
        end else begin
            if (ov4 && !pv4) begin
                if (aq4.size() == 0) flag("unexpected_valid4");
                else chk("latency4", cyc - aq4.pop_front(), 3);
            end
            if (ov4 && or4) begin
                if (q4.size() == 0) flag("unexpected_result4");
                else chk("product4", {24'h0, p4}, {24'h0, q4.pop_front()});
            end
            pv4 = ov4;
        end
    end

    // Drivers are entered #1 after a rising edge and return #1 after the accepting edge.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [15:0] exp, output int acc);
        bit got = 0;
        acc = -1;
        iv8 = 1'b1; a8 = a; b8 = b; s8 = s;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (ir8) begin
                acc = cyc + 1;
                q8.push_back(exp);
                aq8.push_back(acc);
                got = 1;
                break;
            end
        end
        if (!got) flag("accept_timeout8");
        @(posedge clk); #1;
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic s,
                          input logic [7:0] exp);
        bit got = 0;
        iv4 = 1'b1; a4 = a; b4 = b; s4 = s;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (ir4) begin
                q4.push_back(exp);
                aq4.push_back(cyc + 1);
                got = 1;
                break;
            end
        end
        if (!got) flag("accept_timeout4");
        @(posedge clk); #1;
    endtask

    task automatic drain8();
        bit done = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (q8.size() == 0) begin done = 1; break; end
        end
        if (!done) flag("drain_timeout8");
        @(posedge clk); #1;
    endtask

    task automatic drain4();
        bit done = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (q4.size() == 0) begin done = 1; break; end
        end
        if (!done) flag("drain_timeout4");
        @(posedge clk); #1;
    endtask

    function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic s);
        int ia, ib, pr;
        ia = s ? int'($signed(a)) : int'(a);
        ib = s ? int'($signed(b)) : int'(b);
        pr = ia * ib;
        return pr[7:0];
    endfunction

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] exp;
    } vec8_t;

    vec8_t dir8[8] = '{
        '{8'hFB, 8'hF9, 1'b1, 16'h0023},   // -5 * -7
        '{8'h03, 8'hFC, 1'b1, 16'hFFF4},   // 3 * -4
        '{8'h80, 8'h80, 1'b1, 16'h4000},   // MIN * MIN
        '{8'hFF, 8'h01, 1'b1, 16'hFFFF},   // -1 * 1
        '{8'h00, 8'h00, 1'b1, 16'h0000},
        '{8'hFF, 8'hFF, 1'b0, 16'hFE01},   // 255 * 255
        '{8'hC8, 8'h03, 1'b0, 16'h0258},   // 200 * 3
        '{8'hFF, 8'hFF, 1'b1, 16'h0001}    // -1 * -1
    };

    vec8_t b2b8[3] = '{
        '{8'h07, 8'h06, 1'b0, 16'h002A},   // 7 * 6
        '{8'h9C, 8'h02, 1'b1, 16'hFF38},   // -100 * 2
        '{8'h7F, 8'h7F, 1'b0, 16'h3F01}    // 127 * 127
    };

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int accs[3];
        bit bad;
        logic [3:0] ra, rb;
        logic rs;

        rst8 = 1'b0; iv8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; or8 = 1'b1;
        rst4 = 1'b0; iv4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0; or4 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid8", {31'h0, ov8}, 0);
        chk("rst_busy8", {31'h0, busy8}, 0);
        chk("rst_product8", {16'h0, p8}, 0);
        chk("rst_in_ready8", {31'h0, ir8}, 1);
        chk("rst_product4", {24'h0, p4}, 0);
        rst8 = 1'b1; rst4 = 1'b1;
        @(posedge clk); #1;

        foreach (dir8[i]) begin
            issue8(dir8[i].a, dir8[i].b, dir8[i].s, dir8[i].exp, acc);
            iv8 = 1'b0;
            drain8();
        end

        // Backpressure: result must sit unchanged while a competing request is refused.
        or8 = 1'b0;
        issue8(8'h12, 8'h34, 1'b0, 16'h03A8, acc);
        iv8 = 1'b0;
        bad = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ov8) begin bad = 0; break; end
        end
        if (bad) flag("bp_valid_timeout");
        @(posedge clk); #1;
        iv8 = 1'b1; a8 = 8'h55; b8 = 8'h66; s8 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_out_valid", {31'h0, ov8}, 1);
            chk("bp_product", {16'h0, p8}, 32'h03A8);
            chk("bp_in_ready", {31'h0, ir8}, 0);
        end
        @(posedge clk); #1;
        iv8 = 1'b0; or8 = 1'b1;
        drain8();
        repeat (3) @(negedge clk);
        chk("bp_no_extra_busy", {31'h0, busy8}, 0);

        // Back-to-back with in_valid and out_ready held high.
        @(posedge clk); #1;
        foreach (b2b8[i]) begin
            issue8(b2b8[i].a, b2b8[i].b, b2b8[i].s, b2b8[i].exp, acc);
            accs[i] = acc;
        end
        iv8 = 1'b0;
        chk("b2b_spacing_1", accs[1] - accs[0], 6);
        chk("b2b_spacing_2", accs[2] - accs[1], 6);
        drain8();

        // Reset during the third CALC cycle.
        issue8(8'h05, 8'h06, 1'b0, 16'h001E, acc);
        iv8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst8 = 1'b0;
        #1;
        chk("midrst_out_valid", {31'h0, ov8}, 0);
        chk("midrst_busy", {31'h0, busy8}, 0);
        chk("midrst_product", {16'h0, p8}, 0);
        chk("midrst_in_ready", {31'h0, ir8}, 1);
        q8.delete();
        aq8.delete();
        repeat (2) @(negedge clk);
        rst8 = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ov8) bad = 1;
        end
        chk("midrst_no_valid", {31'h0, bad}, 0);
        @(posedge clk); #1;
        issue8(8'hFD, 8'h04, 1'b1, 16'hFFF4, acc);   // -3 * 4
        iv8 = 1'b0;
        drain8();

        // WIDTH=4: directed boundaries, then random sweep against the model.
        issue4(4'h7, 4'h1, 1'b1, 8'h07);
        iv4 = 1'b0;
        drain4();
        issue4(4'h8, 4'h8, 1'b1, 8'h40);
        iv4 = 1'b0;
        drain4();
        issue4(4'hF, 4'hF, 1'b0, 8'hE1);
        iv4 = 1'b0;
        drain4();
        for (int i = 0; i < 1000; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rs = 1'($urandom_range(0, 1));
            issue4(ra, rb, rs, ref4(ra, rb, rs));
        end
        iv4 = 1'b0;
        drain4();

        repeat (5) @(negedge clk);
        chk("final_q8_empty", q8.size(), 0);
        chk("final_q4_empty", q4.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
